// File: rtl/rc5_decrypt.sv
// Iterative RC5-32 block decryptor: one full round per clock, one-cycle done pulse.
// The expanded key table and ciphertext are captured on the accepting edge.
module rc5_decrypt #(
  parameter int ROUNDS = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [32*(2*ROUNDS+2)-1:0]    S,
  input  logic [63:0]                   ct,
  output logic [63:0]                   pt,
  output logic                          busy,
  output logic                          done
);

  localparam int T = 2*ROUNDS + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [3:0]          rnd_r, rnd_s;
  logic [31:0]         a_r, a_s;
  logic [31:0]         b_r, b_s;
  logic [32*T-1:0]     key_r, key_s;
  logic [63:0]         pt_r, pt_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;

  logic [31:0]         b_round_s;
  logic [31:0]         a_round_s;

  // Rotate right by the low five bits of the amount only.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] amt);
    logic [63:0] t;
    t = {x, x} >> amt;
    return t[31:0];
  endfunction

  // Table word select; the loop keeps the index width independent of T.
  function automatic logic [31:0] key_word(input logic [32*T-1:0] tbl, input logic [4:0] idx);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < T; k++) begin
      w = (idx == 5'(k)) ? tbl[32*k +: 32] : w;
    end
    return w;
  endfunction

  assign b_round_s = rotr32(b_r - key_word(key_r, {rnd_r, 1'b1}), a_r[4:0]) ^ a_r;
  assign a_round_s = rotr32(a_r - key_word(key_r, {rnd_r, 1'b0}), b_round_s[4:0]) ^ b_round_s;

  // Next-state and datapath selection for the three-state sequencer.
  always_comb begin
    state_s = state_r;
    rnd_s   = rnd_r;
    a_s     = a_r;
    b_s     = b_r;
    key_s   = key_r;
    pt_s    = pt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_s     = ct[31:0];
          b_s     = ct[63:32];
          key_s   = S;
          rnd_s   = 4'(ROUNDS);
          busy_s  = 1'b1;
          state_s = ROUND;
        end else begin
          state_s = IDLE;
        end
      end
      ROUND: begin
        a_s   = a_round_s;
        b_s   = b_round_s;
        rnd_s = rnd_r - 4'd1;
        if (rnd_r == 4'd1) begin
          state_s = FINAL;
        end else begin
          state_s = ROUND;
        end
      end
      FINAL: begin
        pt_s    = {b_r - key_word(key_r, 5'd1), a_r - key_word(key_r, 5'd0)};
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      rnd_r   <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      key_r   <= '0;
      pt_r    <= 64'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      rnd_r   <= rnd_s;
      a_r     <= a_s;
      b_r     <= b_s;
      key_r   <= key_s;
      pt_r    <= pt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign pt   = pt_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: doc/rc5_decrypt.md
Name: rc5_decrypt

Overview:
- Iterative RC5-32 block decryptor for the search unit: consumes the expanded key table S produced by the key-schedule block and recovers a 64-bit plaintext from a 64-bit ciphertext.
- Executes one full decryption round per clock and signals completion with a one-cycle done pulse.
- Sits downstream of key expansion. The search controller compares its plaintext output against the known-plaintext target.

Parameters:
- ROUNDS, 1, number of RC5 rounds r (1..15); the table holds T = 2*ROUNDS+2 words.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only in IDLE
- S  input  32*(2*ROUNDS+2)  expanded key table; word k is bits [32k+31:32k]
- ct  input  64  ciphertext; A = ct[31:0], B = ct[63:32]
- pt  output  64  plaintext; A = pt[31:0], B = pt[63:32]; held until the next completion
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when pt is valid

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; pt = 0; busy = 0; done = 0.
  - Round counter, A/B registers and the latched key table are all cleared to 0.
- Word arithmetic: all operations are mod 2^32.
  - ROTR(x, y) rotates x right by y[4:0]; only the low 5 bits of the amount are used.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - done = 0 unless completing this edge.
  - On start = 1 at a clock edge: latch ct into A/B, latch the whole S bus internally, set rnd = ROUNDS, busy = 1, go to ROUND.
  - S and ct are don't-care after the latching edge.
- ROUND, one full round per cycle, with i = rnd:
  - B' = ROTR(B - S[2i+1], A) XOR A
  - A' = ROTR(A - S[2i], B') XOR B'
  - Store A', B'; rnd <= rnd - 1.
  - When rnd == 1, go to FINAL.
- FINAL:
  - pt <= {B - S[1], A - S[0]}; done <= 1; busy <= 0; go to IDLE.
  - done drops on the following edge unless a new operation completes.
- Latency: with start high at edge k, done and pt are valid after edge k + ROUNDS + 1. Throughput is one block per ROUNDS + 2 cycles.
- start while busy: ignored, with no queuing.
- start may be asserted in the cycle done is high. That cycle is IDLE, so the request is accepted and the next operation begins back-to-back.
- pt changes only at FINAL edges and is stable between completions.
- Reset mid-operation: immediate abort to the reset values; no done pulse is produced.
- Round index is 4 bits. The table index 2i+1 never exceeds T-1.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: reset low for 2 cycles, then release -> pt = 0, busy = 0, done = 0. Hold start low for 10 cycles -> outputs unchanged.
- ROUNDS = 1, S all zero, ct = {B = 0x00000000, A = 0x00000001}, start pulse at edge k:
  - busy high after edge k.
  - done high after edge k+2 only.
  - pt = {B = 0x00000001, A = 0x80000001}.
- ROUNDS = 12, S = expansion of the all-zero 16-byte key from the reference model, ct = {B = 0x6D8F4B15, A = 0xEEDBA521}:
  - done after exactly 13 cycles.
  - pt = 0x0000000000000000.
- Back-to-back and ignored start:
  - Assert start during the done cycle with a new ct -> the second result arrives ROUNDS+1 edges later.
  - A start pulse while busy -> no effect on rnd or pt.
- Reset abort: start an operation (ROUNDS = 12), pull reset low at cycle 5 -> immediate return to reset values, no done pulse. A new start after release completes normally.
- Randomized round-trip (ROUNDS = 1 and 12, 1000 vectors):
  - Random S and plaintext, encrypted by the model, then fed as ct -> pt equals the original plaintext.
  - Include rotate amounts with bits [31:5] set.
  - S is changed immediately after the latching edge -> the result is unaffected.
